score_board: RTL and testbench
==============================

# score_board

Run accumulator and inning tracker at the consuming end of the scoring pulse interface. Takes the registered one-hot `add_to_score` pulses (1–4 runs per play) from the scoring pulse generator, adds them in BCD to the batting team's score, advances half-innings on `side_out`, and detects the end of the game under nine-inning rules with extra innings. Outputs drive the scoreboard display directly.

## Interface

- `MAX_SCORE`, default 8'h99: BCD saturation value for each team score.
- `LAST_INNING`, default 8'h09: BCD regulation inning count; walk-off and end-of-game checks start here.

- `clk`  in  1  system clock.
- `reset_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `add_to_score`  in  4  one-hot run pulse, bit0=+1, bit1=+2, bit2=+3, bit3=+4; one cycle wide.
- `side_out`  in  1  one-cycle pulse, third out of the current half-inning.
- `new_game`  in  1  one-cycle synchronous clear to the start-of-game state.
- `score_visitor`  out  8  BCD visitor score (two digits).
- `score_home`  out  8  BCD home score (two digits).
- `inning`  out  8  BCD current inning, 01–99.
- `top_half`  out  1  1 = visitor batting, 0 = home batting.
- `game_over`  out  1  level; high when the game has ended.
- `bad_pulse`  out  1  sticky; set when `add_to_score` is non-zero and not one-hot.

## Operation

- State machine: TOP (visitor bats), BOTTOM (home bats), OVER.
- Reset values: scores 8'h00, `inning` 8'h01, `top_half` 1, `game_over` 0, `bad_pulse` 0, state TOP.
- `new_game`: highest priority. Same values as reset, including clearing `bad_pulse`. All other inputs that cycle are ignored.
- Run add:
  - A valid one-hot `add_to_score` adds 1–4 to the batting team's score using two-digit BCD with decimal carry.
  - The result saturates at `MAX_SCORE`.
  - Zero input: no action.
  - Multi-bit input: no score change, sets `bad_pulse`.
- Simultaneous add and `side_out`: the runs are credited to the current batting team first. The side change is then evaluated using the updated scores.
- `side_out` in TOP:
  - If `inning` ≥ `LAST_INNING` and home > visitor, go to OVER.
  - Otherwise go to BOTTOM with `top_half` = 0.
- `side_out` in BOTTOM:
  - If `inning` ≥ `LAST_INNING` and scores differ, go to OVER.
  - Otherwise `inning` +1 in BCD, saturating at 8'h99, then TOP with `top_half` = 1.
- Walk-off: in BOTTOM with `inning` ≥ `LAST_INNING`, if an add makes home > visitor, go to OVER on that same update.
- Score comparisons are unsigned compares on the packed BCD bytes. This is valid because BCD ordering matches numeric ordering.
- OVER:
  - `game_over` = 1.
  - `add_to_score` and `side_out` are ignored, and scores, inning and `top_half` are frozen.
  - Only `new_game` or reset leaves OVER.
- `bad_pulse` is still updated in TOP and BOTTOM only.

## Timing

- All outputs are registered. There is no combinational path from input to output.
- An input sampled at rising edge N is reflected on outputs after edge N. Latency is 1 cycle.
- Back-to-back add pulses on consecutive cycles are each accepted. No idle cycle is required.
- `game_over` rises in the same cycle as the score or state update that ends the game.
- Reset asserted mid-game forces the reset values immediately (asynchronously). Operation resumes on the first edge after release.

## Test plan

- Reset, then one `add_to_score` = 4'b1000 pulse in TOP → `score_visitor` = 8'h04 one cycle later; `score_home` = 8'h00.
- Visitor at 8'h08, add 4'b0100 (+3) → 8'h11 (BCD carry). Visitor at 8'h98, add 4'b1000 → 8'h99 (saturated).
- Nine `side_out` pairs with no runs → `inning` goes 01…09 then 8'h10, `top_half` toggling each pulse, `game_over` = 0 (tied, extra innings).
- Inning 09 BOTTOM, visitor 8'h03, home 8'h02, add 4'b0010 (+2) → home 8'h04, `game_over` = 1 next cycle. A subsequent add or `side_out` changes nothing. `new_game` → all reset values.
- Inning 09 TOP, home 8'h05, visitor 8'h01: `side_out` and 4'b0001 in the same cycle → visitor 8'h02, `game_over` = 1, `top_half` stays 1.
- `add_to_score` = 4'b0110 → scores unchanged, `bad_pulse` = 1 and held across later valid adds, cleared by `new_game`.

Source files
------------

// File: rtl/score_board.sv
// score_board
//   Run accumulator and inning tracker for the scoreboard display.
//   It accepts one-hot run pulses and adds them in BCD to the batting
//   team's score. It advances half-innings on side_out, and detects the
//   end of the game under nine-inning rules with extra innings.
//
// Parameters
//   MAX_SCORE    BCD saturation value for each team score
//   LAST_INNING  BCD regulation inning count (walk-off / end checks start here)
//
// Ports
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   add_to_score   one-hot run pulse: bit0=+1 .. bit3=+4
//   side_out       one-cycle pulse, third out of the half-inning
//   new_game       synchronous clear to start-of-game state (highest priority)
//   score_visitor  BCD visitor score
//   score_home     BCD home score
//   inning         BCD current inning, 01-99
//   top_half       1 = visitor batting, 0 = home batting
//   game_over      high once the game has ended
//   bad_pulse      sticky flag, set on a non-one-hot add_to_score
module score_board #(
    parameter logic [7:0] MAX_SCORE   = 8'h99,
    parameter logic [7:0] LAST_INNING = 8'h09
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] add_to_score,
    input  logic       side_out,
    input  logic       new_game,
    output logic [7:0] score_visitor,
    output logic [7:0] score_home,
    output logic [7:0] inning,
    output logic       top_half,
    output logic       game_over,
    output logic       bad_pulse
);

    typedef enum logic [1:0] {
        S_TOP    = 2'd0,
        S_BOTTOM = 2'd1,
        S_OVER   = 2'd2
    } state_t;

    state_t     state;
    logic [2:0] runs;
    logic       multi_hot;
    logic       late;
    logic [7:0] vis_next;
    logic [7:0] home_next;
    logic [7:0] inning_next;

    // Two-digit BCD add of a small value (0-7) with saturation at sat.
    // A carry out of the tens digit also saturates.
    function automatic logic [7:0] bcd_add(input logic [7:0] a,
                                           input logic [2:0] n,
                                           input logic [7:0] sat);
        logic [4:0] lo;
        logic [4:0] hi;
        logic [7:0] r;
        lo = {1'b0, a[3:0]} + {2'b00, n};
        hi = {1'b0, a[7:4]};
        if (lo > 5'd9) begin
            lo = lo - 5'd10;
            hi = hi + 5'd1;
        end
        if (hi > 5'd9) begin
            r = sat;
        end else begin
            r = {hi[3:0], lo[3:0]};
            if (r > sat) begin
                r = sat;
            end
        end
        return r;
    endfunction

    always_comb begin
        runs = 3'd0;
        case (add_to_score)
            4'b0001: runs = 3'd1;
            4'b0010: runs = 3'd2;
            4'b0100: runs = 3'd3;
            4'b1000: runs = 3'd4;
            default: runs = 3'd0;
        endcase
        multi_hot = (add_to_score != 4'b0000) && (runs == 3'd0);
        late      = (inning >= LAST_INNING);

        // Runs are credited before any side change in the same cycle, so the
        // side_out decisions below compare against these updated scores.
        vis_next  = score_visitor;
        home_next = score_home;
        if (runs != 3'd0) begin
            if (state == S_TOP) begin
                vis_next = bcd_add(score_visitor, runs, MAX_SCORE);
            end else if (state == S_BOTTOM) begin
                home_next = bcd_add(score_home, runs, MAX_SCORE);
            end
        end
        inning_next = bcd_add(inning, 3'd1, 8'h99);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_TOP;
            score_visitor <= '0;
            score_home    <= '0;
            inning        <= 8'h01;
            top_half      <= 1'b1;
            game_over     <= 1'b0;
            bad_pulse     <= 1'b0;
        end else if (new_game) begin
            state         <= S_TOP;
            score_visitor <= '0;
            score_home    <= '0;
            inning        <= 8'h01;
            top_half      <= 1'b1;
            game_over     <= 1'b0;
            bad_pulse     <= 1'b0;
        end else begin
            case (state)
                S_TOP: begin
                    score_visitor <= vis_next;
                    bad_pulse     <= bad_pulse | multi_hot;
                    if (side_out) begin
                        // Home already ahead after the top of a late inning:
                        // the bottom half is not played.
                        if (late && (score_home > vis_next)) begin
                            state     <= S_OVER;
                            game_over <= 1'b1;
                        end else begin
                            state    <= S_BOTTOM;
                            top_half <= 1'b0;
                        end
                    end
                end
                S_BOTTOM: begin
                    score_home <= home_next;
                    bad_pulse  <= bad_pulse | multi_hot;
                    if (side_out) begin
                        if (late && (home_next != score_visitor)) begin
                            state     <= S_OVER;
                            game_over <= 1'b1;
                        end else begin
                            inning   <= inning_next;
                            state    <= S_TOP;
                            top_half <= 1'b1;
                        end
                    end else if ((runs != 3'd0) && late &&
                                 (home_next > score_visitor)) begin
                        // Walk-off: the game ends on the scoring update itself.
                        state     <= S_OVER;
                        game_over <= 1'b1;
                    end
                end
                S_OVER: begin
                end
                default: begin
                    state <= S_TOP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_board.sv
// tb_score_board
//   Self-checking bench for score_board. A reference model keeps the scores
//   and inning as plain integers, applies the game rules directly and
//   converts the result to BCD for comparison with the DUT outputs.
module tb_score_board;

    logic       clk;
    logic       reset_n;
    logic [3:0] add_to_score;
    logic       side_out;
    logic       new_game;
    logic [7:0] score_visitor;
    logic [7:0] score_home;
    logic [7:0] inning;
    logic       top_half;
    logic       game_over;
    logic       bad_pulse;

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_vis;
    int m_home;
    int m_inn;
    bit m_top;
    bit m_over;
    bit m_bad;

    localparam logic [26:0] RESET_VEC = {8'h00, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0};

    score_board #(
        .MAX_SCORE  (8'h99),
        .LAST_INNING(8'h09)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .add_to_score (add_to_score),
        .side_out     (side_out),
        .new_game     (new_game),
        .score_visitor(score_visitor),
        .score_home   (score_home),
        .inning       (inning),
        .top_half     (top_half),
        .game_over    (game_over),
        .bad_pulse    (bad_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic logic [26:0] dut_vec();
        return {score_visitor, score_home, inning, top_half, game_over, bad_pulse};
    endfunction

    function automatic logic [26:0] exp_vec();
        return {to_bcd(m_vis), to_bcd(m_home), to_bcd(m_inn), m_top, m_over, m_bad};
    endfunction

    task automatic model_reset();
        m_vis  = 0;
        m_home = 0;
        m_inn  = 1;
        m_top  = 1'b1;
        m_over = 1'b0;
        m_bad  = 1'b0;
    endtask

    // Game rules on integer scores.
    task automatic model_step(input logic [3:0] a, input logic s, input logic ng);
        int r;
        if (ng) begin
            model_reset();
        end else if (!m_over) begin
            r = 0;
            if (a == 4'b0001) r = 1;
            else if (a == 4'b0010) r = 2;
            else if (a == 4'b0100) r = 3;
            else if (a == 4'b1000) r = 4;
            else if (a != 4'b0000) m_bad = 1'b1;
            if (m_top) m_vis  = (m_vis  + r > 99) ? 99 : m_vis  + r;
            else       m_home = (m_home + r > 99) ? 99 : m_home + r;
            if (s) begin
                if (m_top) begin
                    if (m_inn >= 9 && m_home > m_vis) m_over = 1'b1;
                    else m_top = 1'b0;
                end else begin
                    if (m_inn >= 9 && m_home != m_vis) m_over = 1'b1;
                    else begin
                        m_inn = (m_inn >= 99) ? 99 : m_inn + 1;
                        m_top = 1'b1;
                    end
                end
            end else if (!m_top && r > 0 && m_inn >= 9 && m_home > m_vis) begin
                m_over = 1'b1;
            end
        end
    endtask

    // Apply one cycle of stimulus, advance the model, return #1 after the edge.
    task automatic drive(input logic [3:0] a, input logic s, input logic ng);
        add_to_score = a;
        side_out     = s;
        new_game     = ng;
        @(posedge clk);
        #1;
        model_step(a, s, ng);
        add_to_score = 4'b0000;
        side_out     = 1'b0;
        new_game     = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (dut_vec() !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", dut_vec(), RESET_VEC);
        end
    endtask

    task automatic test_first_add();
        drive(4'b0000, 1'b0, 1'b1);
        drive(4'b1000, 1'b0, 1'b0);
        checks++;
        if (score_visitor !== 8'h04) begin
            errors++;
            $display("FAIL first_add_visitor: got %h expected 04", score_visitor);
        end
        checks++;
        if (score_home !== 8'h00) begin
            errors++;
            $display("FAIL first_add_home: got %h expected 00", score_home);
        end
    endtask

    task automatic test_bcd_carry();
        drive(4'b0000, 1'b0, 1'b1);
        drive(4'b1000, 1'b0, 1'b0);
        drive(4'b1000, 1'b0, 1'b0);
        checks++;
        if (score_visitor !== 8'h08) begin
            errors++;
            $display("FAIL bcd_setup_08: got %h expected 08", score_visitor);
        end
        drive(4'b0100, 1'b0, 1'b0);
        checks++;
        if (score_visitor !== 8'h11) begin
            errors++;
            $display("FAIL bcd_carry_11: got %h expected 11", score_visitor);
        end
        // back-to-back pulses, 11 + 21*4 + 3 = 98
        for (int i = 0; i < 21; i++) drive(4'b1000, 1'b0, 1'b0);
        drive(4'b0100, 1'b0, 1'b0);
        checks++;
        if (score_visitor !== 8'h98) begin
            errors++;
            $display("FAIL back_to_back_98: got %h expected 98", score_visitor);
        end
        drive(4'b1000, 1'b0, 1'b0);
        checks++;
        if (score_visitor !== 8'h99) begin
            errors++;
            $display("FAIL saturate_99: got %h expected 99", score_visitor);
        end
        drive(4'b0001, 1'b0, 1'b0);
        checks++;
        if (score_visitor !== 8'h99) begin
            errors++;
            $display("FAIL saturate_hold: got %h expected 99", score_visitor);
        end
    endtask

    task automatic test_extra_innings();
        drive(4'b0000, 1'b0, 1'b1);
        for (int i = 1; i <= 9; i++) begin
            drive(4'b0000, 1'b1, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec() || top_half !== 1'b0) begin
                errors++;
                $display("FAIL inning_top_side_out %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
            drive(4'b0000, 1'b1, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec() || top_half !== 1'b1) begin
                errors++;
                $display("FAIL inning_bottom_side_out %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (inning !== 8'h10 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL extra_innings: got inning=%h over=%b expected inning=10 over=0", inning, game_over);
        end
    endtask

    task automatic test_walkoff();
        logic [26:0] frozen;
        drive(4'b0000, 1'b0, 1'b1);
        drive(4'b0100, 1'b0, 1'b0);
        drive(4'b0000, 1'b1, 1'b0);
        drive(4'b0010, 1'b0, 1'b0);
        drive(4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            drive(4'b0000, 1'b1, 1'b0);
            drive(4'b0000, 1'b1, 1'b0);
        end
        drive(4'b0000, 1'b1, 1'b0);
        checks++;
        if (dut_vec() !== {8'h03, 8'h02, 8'h09, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL walkoff_setup: got %h expected %h", dut_vec(), {8'h03, 8'h02, 8'h09, 1'b0, 1'b0, 1'b0});
        end
        drive(4'b0010, 1'b0, 1'b0);
        checks++;
        if (score_home !== 8'h04 || game_over !== 1'b1) begin
            errors++;
            $display("FAIL walkoff: got home=%h over=%b expected home=04 over=1", score_home, game_over);
        end
        frozen = {8'h03, 8'h04, 8'h09, 1'b0, 1'b1, 1'b0};
        drive(4'b1000, 1'b0, 1'b0);
        checks++;
        if (dut_vec() !== frozen) begin
            errors++;
            $display("FAIL over_ignores_add: got %h expected %h", dut_vec(), frozen);
        end
        drive(4'b0000, 1'b1, 1'b0);
        checks++;
        if (dut_vec() !== frozen) begin
            errors++;
            $display("FAIL over_ignores_side_out: got %h expected %h", dut_vec(), frozen);
        end
        drive(4'b0101, 1'b0, 1'b0);
        checks++;
        if (dut_vec() !== frozen) begin
            errors++;
            $display("FAIL over_ignores_bad_pulse: got %h expected %h", dut_vec(), frozen);
        end
        drive(4'b0000, 1'b0, 1'b1);
        checks++;
        if (dut_vec() !== RESET_VEC) begin
            errors++;
            $display("FAIL new_game_clear: got %h expected %h", dut_vec(), RESET_VEC);
        end
    endtask

    task automatic test_simultaneous();
        drive(4'b0000, 1'b0, 1'b1);
        drive(4'b0001, 1'b0, 1'b0);
        drive(4'b0000, 1'b1, 1'b0);
        drive(4'b1000, 1'b0, 1'b0);
        drive(4'b0001, 1'b0, 1'b0);
        drive(4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            drive(4'b0000, 1'b1, 1'b0);
            drive(4'b0000, 1'b1, 1'b0);
        end
        checks++;
        if (dut_vec() !== {8'h01, 8'h05, 8'h09, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL top9_setup: got %h expected %h", dut_vec(), {8'h01, 8'h05, 8'h09, 1'b1, 1'b0, 1'b0});
        end
        drive(4'b0001, 1'b1, 1'b0);
        checks++;
        if (dut_vec() !== {8'h02, 8'h05, 8'h09, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL add_with_side_out: got %h expected %h", dut_vec(), {8'h02, 8'h05, 8'h09, 1'b1, 1'b1, 1'b0});
        end
    endtask

    task automatic test_bad_pulse();
        drive(4'b0000, 1'b0, 1'b1);
        drive(4'b0110, 1'b0, 1'b0);
        checks++;
        if (score_visitor !== 8'h00 || score_home !== 8'h00 || bad_pulse !== 1'b1) begin
            errors++;
            $display("FAIL bad_pulse_set: got vis=%h home=%h bad=%b expected 00 00 1", score_visitor, score_home, bad_pulse);
        end
        drive(4'b0001, 1'b0, 1'b0);
        drive(4'b0010, 1'b0, 1'b0);
        checks++;
        if (score_visitor !== 8'h03 || bad_pulse !== 1'b1) begin
            errors++;
            $display("FAIL bad_pulse_sticky: got vis=%h bad=%b expected 03 1", score_visitor, bad_pulse);
        end
        drive(4'b0000, 1'b0, 1'b1);
        checks++;
        if (bad_pulse !== 1'b0) begin
            errors++;
            $display("FAIL bad_pulse_clear: got %b expected 0", bad_pulse);
        end
    endtask

    task automatic test_async_reset();
        drive(4'b0000, 1'b0, 1'b1);
        drive(4'b1000, 1'b0, 1'b0);
        drive(4'b0000, 1'b1, 1'b0);
        drive(4'b0010, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dut_vec() !== RESET_VEC) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", dut_vec(), RESET_VEC);
        end
        drive(4'b1000, 1'b1, 1'b0);
        model_reset();
        checks++;
        if (dut_vec() !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_held: got %h expected %h", dut_vec(), RESET_VEC);
        end
        @(negedge clk);
        reset_n = 1'b1;
        drive(4'b0001, 1'b0, 1'b0);
        checks++;
        if (score_visitor !== 8'h01) begin
            errors++;
            $display("FAIL resume_after_reset: got %h expected 01", score_visitor);
        end
    endtask

    task automatic test_random();
        logic [3:0] a;
        logic       s;
        logic       ng;
        int         r;
        int         over_cycles;
        int         prints;
        over_cycles = 0;
        prints = 0;
        drive(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 40) begin
                a = 4'(1 << $urandom_range(0, 3));
            end else if (r < 42) begin
                a = 4'($urandom_range(0, 15));
                if (a == 4'b0000 || a == 4'b0001 || a == 4'b0010 ||
                    a == 4'b0100 || a == 4'b1000) a = 4'b1010;
            end else begin
                a = 4'b0000;
            end
            s  = ($urandom_range(0, 3) == 0);
            ng = ($urandom_range(0, 299) == 0) || (over_cycles > 20);
            drive(a, s, ng);
            over_cycles = m_over ? over_cycles + 1 : 0;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                if (prints < 20) begin
                    prints++;
                    $display("FAIL random_cycle %0d: got %h expected %h", i, dut_vec(), exp_vec());
                end
            end
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        add_to_score = 4'b0000;
        side_out     = 1'b0;
        new_game     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset_n = 1'b1;
        test_first_add();
        test_bcd_carry();
        test_extra_innings();
        test_walkoff();
        test_simultaneous();
        test_bad_pulse();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
